// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - dual-lane ID/EX register with forwarded-operand resolution and stall capture.
// Optional FWD_SEL_CHECK_EN builds a sticky illegal-forward-select detector (fwdErr).
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallE,
  input  logic              flushE,
  input  logic              validD1, validD2,
  input  logic [REG_W-1:0]  rsD1, rtD1, rsD2, rtD2,
  input  logic [REG_W-1:0]  rdD1, rdD2,
  input  logic              regWriteD1, regWriteD2,
  input  logic [DATA_W-1:0] rsValD1, rtValD1, rsValD2, rtValD2,
  input  logic [2:0]        ForwardA1, ForwardB1, ForwardA2, ForwardB2,
  input  logic [DATA_W-1:0] resultM1, resultM2, resultW1, resultW2,
  output logic [REG_W-1:0]  rsE1, rtE1, rsE2, rtE2,
  output logic [REG_W-1:0]  writeRegisterE1, writeRegisterE2,
  output logic              regWriteE1, regWriteE2,
  output logic              validE1, validE2,
  output logic [DATA_W-1:0] srcA1E, srcB1E, srcA2E, srcB2E,
  output logic              fwdErr
);

  logic [1:0]             valid_q, regwrite_q;
  logic [1:0][REG_W-1:0]  rs_q, rt_q, rd_q;
  logic [1:0][DATA_W-1:0] rsval_q, rtval_q;
  logic [3:0]             cap_q;
  logic [3:0][DATA_W-1:0] hold_q;

  // Operand slots: 0=A1, 1=B1, 2=A2, 3=B2
  logic [3:0][REG_W-1:0]  idx;
  logic [3:0][DATA_W-1:0] rfval;
  logic [3:0][2:0]        sel;
  logic [3:0][DATA_W-1:0] res;

  assign idx   = {rt_q[1], rs_q[1], rt_q[0], rs_q[0]};
  assign rfval = {rtval_q[1], rsval_q[1], rtval_q[0], rsval_q[0]};
  assign sel   = {ForwardB2, ForwardA2, ForwardB1, ForwardA1};

  always_comb begin
    res = '0;
    for (int k = 0; k < 4; k++) begin
      if (idx[k] == '0) begin
        res[k] = '0;
      end else if (cap_q[k]) begin
        res[k] = hold_q[k];
      end else begin
        case (sel[k])
          3'b001:  res[k] = resultM1;
          3'b010:  res[k] = resultM2;
          3'b011:  res[k] = resultW1;
          3'b100:  res[k] = resultW2;
          default: res[k] = rfval[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rsval_q    <= '0;
      rtval_q    <= '0;
      cap_q      <= '0;
      hold_q     <= '0;
    end else if (flushE) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rsval_q    <= '0;
      rtval_q    <= '0;
      cap_q      <= '0;
      hold_q     <= '0;
    end else if (stallE) begin
      // Freeze each operand once so forwarded data survives producer retirement
      for (int k = 0; k < 4; k++) begin
        if (!cap_q[k]) begin
          hold_q[k] <= res[k];
          cap_q[k]  <= 1'b1;
        end
      end
    end else begin
      valid_q    <= {validD2, validD1};
      regwrite_q <= {regWriteD2 & validD2, regWriteD1 & validD1};
      rs_q       <= {rsD2, rsD1};
      rt_q       <= {rtD2, rtD1};
      rd_q       <= {rdD2, rdD1};
      rsval_q    <= {rsValD2, rsValD1};
      rtval_q    <= {rtValD2, rtValD1};
      cap_q      <= '0;
    end
  end

`ifdef FWD_SEL_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    for (int k = 0; k < 4; k++) begin
      if (valid_q[k/2] && (sel[k] >= 3'd5) && (idx[k] != '0) && !cap_q[k]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign fwdErr = err_q;
`else
  assign fwdErr = 1'b0;
`endif

  assign rsE1            = rs_q[0];
  assign rtE1            = rt_q[0];
  assign rsE2            = rs_q[1];
  assign rtE2            = rt_q[1];
  assign writeRegisterE1 = rd_q[0];
  assign writeRegisterE2 = rd_q[1];
  assign regWriteE1      = regwrite_q[0];
  assign regWriteE2      = regwrite_q[1];
  assign validE1         = valid_q[0];
  assign validE2         = valid_q[1];
  assign srcA1E          = res[0];
  assign srcB1E          = res[1];
  assign srcA2E          = res[2];
  assign srcB2E          = res[3];

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed plus randomized checks of ex_operand_stage against a behavioural model.
module tb_ex_operand_stage;
  logic clk = 1'b0;
  logic rst;
  logic stallE, flushE;
  logic        v_in [2];
  logic        rw_in [2];
  logic [4:0]  rs_in [2], rt_in [2], rd_in [2];
  logic [31:0] rsv_in [2], rtv_in [2];
  logic [2:0]  fwd [4];
  logic [31:0] res_in [4];  // M1, M2, W1, W2

  logic [4:0]  o_rs [2], o_rt [2], o_wr [2];
  logic        o_rw [2], o_v [2];
  logic [31:0] o_src [4];
  logic        o_err;

  always #5 clk = ~clk;

  ex_operand_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE),
    .validD1(v_in[0]), .validD2(v_in[1]),
    .rsD1(rs_in[0]), .rtD1(rt_in[0]), .rsD2(rs_in[1]), .rtD2(rt_in[1]),
    .rdD1(rd_in[0]), .rdD2(rd_in[1]),
    .regWriteD1(rw_in[0]), .regWriteD2(rw_in[1]),
    .rsValD1(rsv_in[0]), .rtValD1(rtv_in[0]), .rsValD2(rsv_in[1]), .rtValD2(rtv_in[1]),
    .ForwardA1(fwd[0]), .ForwardB1(fwd[1]), .ForwardA2(fwd[2]), .ForwardB2(fwd[3]),
    .resultM1(res_in[0]), .resultM2(res_in[1]), .resultW1(res_in[2]), .resultW2(res_in[3]),
    .rsE1(o_rs[0]), .rtE1(o_rt[0]), .rsE2(o_rs[1]), .rtE2(o_rt[1]),
    .writeRegisterE1(o_wr[0]), .writeRegisterE2(o_wr[1]),
    .regWriteE1(o_rw[0]), .regWriteE2(o_rw[1]),
    .validE1(o_v[0]), .validE2(o_v[1]),
    .srcA1E(o_src[0]), .srcB1E(o_src[1]), .srcA2E(o_src[2]), .srcB2E(o_src[3]),
    .fwdErr(o_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: what each lane holds in EX and which operands are frozen
  bit          m_v [2], m_rw [2];
  bit [4:0]    m_rs [2], m_rt [2], m_rd [2];
  bit [31:0]   m_rsv [2], m_rtv [2];
  bit          m_held [4];
  bit [31:0]   m_hval [4];
  bit          m_err;

  function automatic bit [4:0] m_idx(int k);
    return (k % 2 == 0) ? m_rs[k/2] : m_rt[k/2];
  endfunction

  function automatic bit [31:0] exp_src(int k);
    bit [31:0] rf;
    rf = (k % 2 == 0) ? m_rsv[k/2] : m_rtv[k/2];
    if (m_idx(k) == 0) return 32'h0;
    if (m_held[k]) return m_hval[k];
    if (fwd[k] >= 3'd1 && fwd[k] <= 3'd4) return res_in[fwd[k] - 3'd1];
    return rf;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_v[l] = 0; m_rw[l] = 0; m_rs[l] = 0; m_rt[l] = 0; m_rd[l] = 0; m_rsv[l] = 0; m_rtv[l] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      m_held[k] = 0; m_hval[k] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_edge();
    bit [31:0] cur [4];
`ifdef FWD_SEL_CHECK_EN
    for (int k = 0; k < 4; k++)
      if (m_v[k/2] && fwd[k] >= 3'd5 && m_idx(k) != 0 && !m_held[k]) m_err = 1;
`endif
    for (int k = 0; k < 4; k++) cur[k] = exp_src(k);
    if (flushE) begin
      for (int l = 0; l < 2; l++) begin
        m_v[l] = 0; m_rw[l] = 0; m_rs[l] = 0; m_rt[l] = 0; m_rd[l] = 0; m_rsv[l] = 0; m_rtv[l] = 0;
      end
      for (int k = 0; k < 4; k++) begin
        m_held[k] = 0; m_hval[k] = 0;
      end
    end else if (stallE) begin
      for (int k = 0; k < 4; k++)
        if (!m_held[k]) begin
          m_hval[k] = cur[k];
          m_held[k] = 1;
        end
    end else begin
      for (int l = 0; l < 2; l++) begin
        m_v[l] = v_in[l]; m_rw[l] = rw_in[l] && v_in[l];
        m_rs[l] = rs_in[l]; m_rt[l] = rt_in[l]; m_rd[l] = rd_in[l];
        m_rsv[l] = rsv_in[l]; m_rtv[l] = rtv_in[l];
      end
      for (int k = 0; k < 4; k++) m_held[k] = 0;
    end
  endtask

  task automatic compare_all();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("rsE%0d", l + 1), o_rs[l], m_rs[l]);
      check($sformatf("rtE%0d", l + 1), o_rt[l], m_rt[l]);
      check($sformatf("wrE%0d", l + 1), o_wr[l], m_rd[l]);
      check($sformatf("regWriteE%0d", l + 1), o_rw[l], m_rw[l]);
      check($sformatf("validE%0d", l + 1), o_v[l], m_v[l]);
    end
    for (int k = 0; k < 4; k++) check($sformatf("src%0d", k), o_src[k], exp_src(k));
    check("fwdErr", o_err, m_err);
  endtask

  // Inputs change only just after a falling edge; the model advances right after each rising edge
  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stallE = 0; flushE = 0;
    for (int l = 0; l < 2; l++) begin
      v_in[l] = 0; rw_in[l] = 0; rs_in[l] = 0; rt_in[l] = 0; rd_in[l] = 0; rsv_in[l] = 0; rtv_in[l] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      fwd[k] = 0; res_in[k] = 0;
    end
  endtask

  task automatic randomize_inputs();
    stallE = ($urandom_range(0, 99) < 40);
    flushE = ($urandom_range(0, 99) < 8);
    for (int l = 0; l < 2; l++) begin
      v_in[l] = $urandom_range(0, 1); rw_in[l] = $urandom_range(0, 1);
      rs_in[l] = 5'($urandom_range(0, 7)); rt_in[l] = 5'($urandom_range(0, 7));
      rd_in[l] = 5'($urandom); rsv_in[l] = $urandom; rtv_in[l] = $urandom;
    end
    for (int k = 0; k < 4; k++) begin
      fwd[k] = 3'($urandom_range(0, 7)); res_in[k] = $urandom;
    end
  endtask

  bit exp_err_const;

  initial begin
`ifdef FWD_SEL_CHECK_EN
    exp_err_const = 1;
`else
    exp_err_const = 0;
`endif
    clear_inputs();
    rst = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    // Reset with busy inputs, asserted mid-cycle with no edge
    randomize_inputs();
    stallE = 0; flushE = 0;
    step();
    stallE = 1;
    step();
    #2 rst = 0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) check("rst_src", o_src[k], 32'h0);
    check("rst_valid", {o_v[1], o_v[0]}, 2'b00);
    check("rst_rs", {o_rs[1], o_rs[0]}, 10'h0);
    check("rst_err", o_err, 1'b0);
    @(negedge clk);
    rst = 1;
    clear_inputs();

    // Advance then forward from M1
    rs_in[0] = 3; rsv_in[0] = 32'h11; v_in[0] = 1;
    step();
    fwd[0] = 3'b001; res_in[0] = 32'hAA;
    #1 check("adv_rsE1", o_rs[0], 5'd3);
    check("adv_fwdM1", o_src[0], 32'hAA);
    fwd[0] = 3'b000;
    #1 check("adv_rf", o_src[0], 32'h11);

    // Stall capture of a W2-forwarded operand
    rt_in[1] = 7; rtv_in[1] = 32'h33; v_in[1] = 1;
    step();
    fwd[3] = 3'b100; res_in[3] = 32'h55; stallE = 1;
    rt_in[1] = 9;
    step();
    res_in[3] = 32'h99; fwd[3] = 3'b000;
    #1 check("stall_c1", o_src[3], 32'h55);
    step();
    check("stall_c2", o_src[3], 32'h55);
    step();
    check("stall_c3", o_src[3], 32'h55);
    check("stall_rtE2", o_rt[1], 5'd7);
    stallE = 0;
    step();
    check("release_rtE2", o_rt[1], 5'd9);
    check("release_src", o_src[3], 32'h33);

    // Flush wins over stall
    stallE = 1; flushE = 1;
    step();
    check("flush_valid", {o_v[1], o_v[0]}, 2'b00);
    check("flush_rw", {o_rw[1], o_rw[0]}, 2'b00);
    check("flush_idx", {o_rs[0], o_rt[0], o_rs[1], o_rt[1]}, 20'h0);
    stallE = 0; flushE = 0;

    // Zero index and invalid lane
    rs_in[1] = 0; fwd[2] = 3'b001; res_in[0] = 32'hFFFF_FFFF; v_in[1] = 0; rw_in[1] = 1;
    step();
    #1 check("zero_idx", o_src[2], 32'h0);
    check("inv_lane_rw", o_rw[1], 1'b0);

    // Illegal select falls back to register-file value
    fwd[0] = 3'b110; rs_in[0] = 4; rsv_in[0] = 32'h44; v_in[0] = 1;
    step();
    check("illegal_src", o_src[0], 32'h44);
    step();
    check("illegal_err", o_err, exp_err_const);
    fwd[0] = 3'b000;
    step();
    check("err_sticky", o_err, exp_err_const);

    // Randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      if ($urandom_range(0, 99) == 0) begin
        rst = 0;
        model_reset();
        #1 compare_all();
        rst = 1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
